// File: rtl/ripple_count_capture_if.sv
// Bundle of the ripple-capture signals: the ripple counter and control inputs, and the
// filtered count, pulses and flags sent back to the synchronous logic.
interface ripple_count_capture_if #(
    parameter int EXT_WIDTH = 12
);
    logic [3:0]           ripple_q;
    logic                 enable;
    logic [EXT_WIDTH-1:0] threshold;
    logic                 ack;
    logic [3:0]           count_stable;
    logic [EXT_WIDTH-1:0] count_ext;
    logic                 change_pulse;
    logic                 wrap_pulse;
    logic                 thresh_hit;
    logic                 ext_overflow;

    modport master (
        output ripple_q, enable, threshold, ack,
        input  count_stable, count_ext, change_pulse, wrap_pulse, thresh_hit, ext_overflow
    );

    modport slave (
        input  ripple_q, enable, threshold, ack,
        output count_stable, count_ext, change_pulse, wrap_pulse, thresh_hit, ext_overflow
    );
endinterface

// File: rtl/ripple_count_capture.sv
// Samples a 4-bit asynchronous ripple counter and accepts a value only after it has held
// steady. Accepted steps are accumulated into a wide count with wrap, overflow and threshold flags.
module ripple_count_capture #(
    parameter int EXT_WIDTH     = 12,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   clear,
    ripple_count_capture_if.slave  bus
);
    typedef enum logic [1:0] {ACQUIRE, TRACK, HOLD} state_t;

    localparam logic [3:0] RUN_NEED = 4'(STABLE_CYCLES - 1);

    logic [3:0]           sync_1_reg;
    logic [3:0]           sync_2_reg;
    logic [3:0]           cand_reg;
    logic [3:0]           run_reg;
    logic [2:0]           fill_reg;
    state_t               state_reg;
    logic [3:0]           count_stable_reg;
    logic [EXT_WIDTH-1:0] count_ext_reg;
    logic                 change_pulse_reg;
    logic                 wrap_pulse_reg;
    logic                 thresh_hit_reg;
    logic                 ext_overflow_reg;

    logic                 stable;
    logic                 do_update;
    logic [3:0]           delta;
    logic [EXT_WIDTH:0]   sum;
    logic                 crossing;

    // The cleared contents of the chain are not real samples; fill_reg marks when
    // sync_1, sync_2 and cand each hold data taken from ripple_q.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync_1_reg <= 4'd0;
            sync_2_reg <= 4'd0;
            cand_reg   <= 4'd0;
            run_reg    <= 4'd0;
            fill_reg   <= 3'd0;
        end else begin
            sync_1_reg <= bus.ripple_q;
            sync_2_reg <= sync_1_reg;
            cand_reg   <= sync_2_reg;
            fill_reg   <= {fill_reg[1:0], 1'b1};
            if (fill_reg[2] && (sync_2_reg == cand_reg)) begin
                if (run_reg != 4'hF) begin
                    run_reg <= run_reg + 4'd1;
                end
            end else begin
                run_reg <= 4'd0;
            end
        end
    end

    assign stable    = fill_reg[2] && (sync_2_reg == cand_reg) && (run_reg >= RUN_NEED);
    assign do_update = bus.enable && (state_reg == TRACK) && stable
                       && (sync_2_reg != count_stable_reg);
    assign delta     = sync_2_reg - count_stable_reg;
    assign sum       = {1'b0, count_ext_reg} + {{(EXT_WIDTH-3){1'b0}}, delta};
    // A carry means the count passed through every value up to all-ones, so landing
    // at or above threshold after wrapping also counts as a crossing.
    assign crossing  = ((count_ext_reg < bus.threshold) || sum[EXT_WIDTH])
                       && (sum[EXT_WIDTH-1:0] >= bus.threshold);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg        <= ACQUIRE;
            count_stable_reg <= 4'd0;
            count_ext_reg    <= '0;
            change_pulse_reg <= 1'b0;
            wrap_pulse_reg   <= 1'b0;
            thresh_hit_reg   <= 1'b0;
            ext_overflow_reg <= 1'b0;
        end else begin
            change_pulse_reg <= 1'b0;
            wrap_pulse_reg   <= 1'b0;

            if (do_update && crossing) begin
                thresh_hit_reg <= 1'b1;
            end else if (bus.ack) begin
                thresh_hit_reg <= 1'b0;
            end

            if (do_update && sum[EXT_WIDTH]) begin
                ext_overflow_reg <= 1'b1;
            end else if (bus.ack) begin
                ext_overflow_reg <= 1'b0;
            end

            if (!bus.enable) begin
                state_reg <= HOLD;
            end else begin
                case (state_reg)
                    HOLD: state_reg <= ACQUIRE;
                    ACQUIRE: begin
                        if (stable) begin
                            count_stable_reg <= sync_2_reg;
                            state_reg        <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (do_update) begin
                            count_ext_reg    <= sum[EXT_WIDTH-1:0];
                            count_stable_reg <= sync_2_reg;
                            change_pulse_reg <= 1'b1;
                            wrap_pulse_reg   <= (sync_2_reg < count_stable_reg);
                        end
                    end
                    default: state_reg <= ACQUIRE;
                endcase
            end
        end
    end

    assign bus.count_stable = count_stable_reg;
    assign bus.count_ext    = count_ext_reg;
    assign bus.change_pulse = change_pulse_reg;
    assign bus.wrap_pulse   = wrap_pulse_reg;
    assign bus.thresh_hit   = thresh_hit_reg;
    assign bus.ext_overflow = ext_overflow_reg;
endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit asynchronous ripple up-counter; brings its transiently-invalid ripple outputs into the synchronous `clk` domain.
- Accepts a counter value only once it is stable, extends it to a wide event count, and flags wrap, overflow and threshold crossings.
- Sits between the ripple counter and the synchronous status/interrupt logic.

Parameters:
EXT_WIDTH, 12, width of the extended count accumulator (min 5).
STABLE_CYCLES, 2, consecutive identical synchronized samples required before acceptance (min 2, max 15).

Ports:
clk  input  1  system clock; all state on rising edge
clear  input  1  asynchronous active-low reset
ripple_q  input  4  raw Q outputs of the ripple counter (asynchronous to clk)
enable  input  1  1 = count, 0 = hold all counts
threshold  input  EXT_WIDTH  compare value for thresh_hit
ack  input  1  clears sticky thresh_hit and ext_overflow
count_stable  output  4  last accepted ripple value
count_ext  output  EXT_WIDTH  extended event count
change_pulse  output  1  one-cycle pulse when an accepted value differs from the previous one
wrap_pulse  output  1  one-cycle pulse when an accepted update wrapped through 15->0
thresh_hit  output  1  sticky; count_ext reached threshold
ext_overflow  output  1  sticky; count_ext carried out of EXT_WIDTH

Behaviour:
- Reset (clear=0, asynchronous): sync regs, candidate, run counter, count_stable, count_ext = 0; all pulses and flags = 0; FSM = ACQUIRE.
- Synchronizer: 2-flop chain sync_1 -> sync_2 on ripple_q; no other logic may sample ripple_q.
- Stability filter (always running):
  - cand <= sync_2.
  - If sync_2 == cand, run saturates upward; otherwise run <= 0.
  - A value is "stable" when sync_2 has been identical for STABLE_CYCLES consecutive clocks.
  - Latency: ripple_q settled before edge 0 -> outputs update at edge STABLE_CYCLES+2 (edge 4 by default).
  - Any glitch restarts the run; a value that never holds STABLE_CYCLES clocks is never accepted.
- FSM:
  - ACQUIRE: first stable value v loads count_stable=v as baseline. count_ext unchanged; no pulses. -> TRACK.
  - TRACK: on each stable value v != count_stable:
    - delta = (v - count_stable) mod 16; count_ext += delta (multi-step jumps allowed, 1..15).
    - count_stable <= v; change_pulse=1.
    - wrap_pulse=1 if v < old count_stable.
    - A stable value equal to count_stable produces no action.
  - HOLD: entered from any state when enable=0. No updates, no pulses; outputs frozen; the filter keeps running.
  - enable 0->1: -> ACQUIRE. Events during HOLD are intentionally discarded.
- Overflow: a carry out of EXT_WIDTH bits in count_ext sets ext_overflow; count_ext wraps modulo 2^EXT_WIDTH.
- Threshold:
  - thresh_hit sets on the cycle count_ext transitions from < threshold to >= threshold, or when an update wraps count_ext through 0 past threshold.
  - Level-held until ack.
  - ack clears both sticky flags. If set and ack occur in the same cycle, set wins.
  - A threshold change alone does not set the flag.
- Pulses are exactly one clk wide and registered; their timing is coincident with the count_stable update.
- clear asserted mid-operation: immediate return to reset values. After release, first stable value is a baseline only (ACQUIRE).

Test Plan:
1. Reset release with ripple_q=4'd3 held -> count_stable=3 at edge 4, count_ext=0, no change_pulse.
2. From baseline 3, step ripple_q 3->4->5, each held 6 clocks -> count_ext 1 then 2; change_pulse once per step; wrap_pulse=0.
3. Ripple transient 7->6->4->8 (intermediates 1 clock each) from baseline 7 -> only 8 accepted; count_ext += 1; exactly one change_pulse.
4. Baseline 14, jump to 2 held -> count_ext += 4, wrap_pulse=1 concurrent with change_pulse.
5. EXT_WIDTH=5, threshold=30, count_ext=28, step +3 -> count_ext=31, thresh_hit=1. Next +2 -> count_ext=1, ext_overflow=1. ack pulse -> both 0. ack coincident with a new crossing -> thresh_hit stays 1.
6. enable=0 while ripple advances 5->9, then enable=1 -> ACQUIRE loads 9, count_ext unchanged. clear pulsed mid-run -> all outputs 0 immediately.
